// File: rtl/pc_update.sv
// pc_update: next-PC stage that owns the architectural PC and hands fetch addresses over a valid/ready handshake.
// Optional MISALIGN_TRAP_EN: redirects to TRAP_VECTOR when the target has bit1 set, and reports it on the trap ports.
module pc_update #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_de,
  input  logic [XLEN-1:0] imm_de,
  input  logic [XLEN-1:0] rs1data_de,
  input  logic [1:0]      jump_kind_de,
  input  logic            jump_state_pre,
  input  logic            ex_valid,
  output logic            ex_ready,
  output logic [XLEN-1:0] pc_fe,
  output logic            pc_valid_fe,
  input  logic            fetch_ready_fe,
  output logic [XLEN-1:0] link_pc,
  output logic            trap_misalign,
  output logic [XLEN-1:0] mtval_misalign
);
  typedef enum logic [1:0] {BOOT, ISSUE, RESOLVE} state_t;
  state_t          r_state, w_next_state;
  logic [XLEN-1:0] r_pc, r_link, w_sum, w_target, w_next_pc;
  logic            w_redirect, w_accept, w_misalign;
  // jump_state_pre is masked by the kind compare first, so an X there cannot leak when kind is 00/11
  assign w_redirect = (jump_kind_de == 2'b10) | ((jump_kind_de == 2'b01) & jump_state_pre);
  assign w_sum      = (jump_kind_de == 2'b10) ? rs1data_de + imm_de : pc_de + imm_de;
  assign w_target   = {w_sum[XLEN-1:1], 1'b0};
  assign w_next_pc  = w_redirect ? w_target : pc_de + XLEN'(4);
  assign w_accept   = (r_state == RESOLVE) & ex_valid;
  assign pc_fe      = r_pc;
  assign link_pc    = r_link;
  always_comb begin
    w_next_state = r_state;
    pc_valid_fe  = 1'b0;
    ex_ready     = 1'b0;
    case (r_state)
      BOOT:    w_next_state = ISSUE;
      ISSUE: begin
        pc_valid_fe = 1'b1;
        if (fetch_ready_fe) w_next_state = RESOLVE;
      end
      RESOLVE: begin
        ex_ready = 1'b1;
        if (ex_valid) w_next_state = ISSUE;
      end
      default: w_next_state = BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_link  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_pc   <= w_misalign ? TRAP_VECTOR : w_next_pc;
        r_link <= pc_de + XLEN'(4);
      end
    end
  end
`ifdef MISALIGN_TRAP_EN
  logic            r_trap;
  logic [XLEN-1:0] r_mtval;
  assign w_misalign     = w_redirect & w_target[1];
  assign trap_misalign  = r_trap;
  assign mtval_misalign = r_mtval;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap  <= 1'b0;
      r_mtval <= '0;
    end else begin
      r_trap <= w_accept & w_misalign;
      if (w_accept & w_misalign) r_mtval <= w_target;
    end
  end
`else
  assign w_misalign     = 1'b0;
  assign trap_misalign  = 1'b0;
  assign mtval_misalign = '0;
`endif
endmodule
